// File: rtl/divider_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_CNT_W = $clog2(DEF_WIDTH);

    // Step-counter width for a given operand width; must hold WIDTH-1.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: shift in the next dividend bit, trial-subtract D.
module div_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] r_i,
    input  logic             q_msb_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] r_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] sub;
    logic [WIDTH:0] diff;
    logic [WIDTH:0] borrow;

    assign shifted   = {r_i, q_msb_i};
    assign sub       = {1'b0, d_i};
    assign borrow[0] = 1'b0;

    // Ripple of full-subtractor cells across the WIDTH+1-bit datapath.
    for (genvar i = 0; i <= WIDTH; i++) begin : g_diff
        assign diff[i] = shifted[i] ^ sub[i] ^ borrow[i];
    end
    for (genvar i = 0; i < WIDTH; i++) begin : g_borrow
        assign borrow[i+1] = (~shifted[i] & sub[i]) | (~(shifted[i] ^ sub[i]) & borrow[i]);
    end

    assign q_bit_o = ~diff[WIDTH];
    assign r_o     = q_bit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring unsigned divider, one quotient bit per clock.
module seq_divider
    import divider_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_t           state_q;
    logic [CNT_W-1:0] count_q;
    // Partial remainder stays below D, so its WIDTH+1-th bit is always zero and not stored.
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;

    logic [WIDTH-1:0] r_d;
    logic             q_bit_d;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r_i     (r_q),
        .q_msb_i (q_q[WIDTH-1]),
        .d_i     (d_q),
        .r_o     (r_d),
        .q_bit_o (q_bit_d)
    );

    // Control FSM and datapath registers; results load only on entry to DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        r_q     <= '0;
                        q_q     <= dividend;
                        d_q     <= divisor;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        if (divisor != '0) begin
                            state_q <= RUN;
                        end else begin
                            state_q     <= DONE;
                            done_q      <= 1'b1;
                            quotient_q  <= '1;
                            remainder_q <= dividend;
                            dbz_q       <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    r_q     <= r_d;
                    q_q     <= {q_q[WIDTH-2:0], q_bit_d};
                    count_q <= count_q + CNT_W'(1);
                    if (count_q == CNT_W'(WIDTH - 1)) begin
                        state_q     <= DONE;
                        done_q      <= 1'b1;
                        quotient_q  <= {q_q[WIDTH-2:0], q_bit_d};
                        remainder_q <= r_d;
                        dbz_q       <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=8) against a plain-arithmetic reference.
module tb_seq_divider;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int vectors = 0;
    int miscompares = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Advance one cycle and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start one operation now and wait (bounded) for done; lat = cycle offset of done or -1.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic z,
                         output int lat, output bit busy_ok, output bit pulse_ok);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        step();
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        lat      = 1;
        busy_ok  = 1'b1;
        while (done !== 1'b1 && lat <= int'(W) + 4) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            step();
            lat++;
        end
        if (busy !== 1'b1) busy_ok = 1'b0;
        if (done !== 1'b1) lat = -1;
        q = quotient;
        r = remainder;
        z = div_by_zero;
        step();
        pulse_ok = (done === 1'b0) && (busy === 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) step();
        vectors += 5;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", done); end
        if (quotient !== 8'h00) begin miscompares++; $display("FAIL reset_quot got=%h exp=00", quotient); end
        if (remainder !== 8'h00) begin miscompares++; $display("FAIL reset_rem got=%h exp=00", remainder); end
        if (div_by_zero !== 1'b0) begin miscompares++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [W-1:0] ta [4] = '{8'd100, 8'd255, 8'd5, 8'd255};
        logic [W-1:0] tb [4] = '{8'd7, 8'd1, 8'd9, 8'd255};
        logic [W-1:0] eq [4] = '{8'd14, 8'd255, 8'd0, 8'd1};
        logic [W-1:0] er [4] = '{8'd2, 8'd0, 8'd5, 8'd0};
        logic [W-1:0] q, r;
        logic z;
        int lat;
        bit bok, pok;
        for (int i = 0; i < 4; i++) begin
            do_op(ta[i], tb[i], q, r, z, lat, bok, pok);
            vectors += 6;
            if (q !== eq[i]) begin miscompares++; $display("FAIL basic_quot[%0d] got=%0d exp=%0d", i, q, eq[i]); end
            if (r !== er[i]) begin miscompares++; $display("FAIL basic_rem[%0d] got=%0d exp=%0d", i, r, er[i]); end
            if (z !== 1'b0) begin miscompares++; $display("FAIL basic_dbz[%0d] got=%b exp=0", i, z); end
            if (lat != int'(W) + 1) begin miscompares++; $display("FAIL basic_latency[%0d] got=%0d exp=%0d", i, lat, W + 1); end
            if (!bok) begin miscompares++; $display("FAIL basic_busy[%0d] got=low exp=high during op", i); end
            if (!pok) begin miscompares++; $display("FAIL basic_done_width[%0d] got=done/busy high after done exp=low", i); end
        end
    endtask

    task automatic test_div_zero();
        logic [W-1:0] q, r;
        logic z;
        int lat;
        bit bok, pok;
        do_op(8'h3C, 8'h00, q, r, z, lat, bok, pok);
        vectors += 5;
        if (lat != 1) begin miscompares++; $display("FAIL dbz_latency got=%0d exp=1", lat); end
        if (q !== 8'hFF) begin miscompares++; $display("FAIL dbz_quot got=%h exp=ff", q); end
        if (r !== 8'h3C) begin miscompares++; $display("FAIL dbz_rem got=%h exp=3c", r); end
        if (z !== 1'b1) begin miscompares++; $display("FAIL dbz_flag got=%b exp=1", z); end
        if (!pok) begin miscompares++; $display("FAIL dbz_done_width got=high exp=low"); end
        do_op(8'd10, 8'd3, q, r, z, lat, bok, pok);
        vectors += 3;
        if (q !== 8'd3) begin miscompares++; $display("FAIL dbz_clear_quot got=%0d exp=3", q); end
        if (r !== 8'd1) begin miscompares++; $display("FAIL dbz_clear_rem got=%0d exp=1", r); end
        if (z !== 1'b0) begin miscompares++; $display("FAIL dbz_clear_flag got=%b exp=0", z); end
    endtask

    task automatic test_ignore_start();
        int t = 0;
        dividend = 8'd200; divisor = 8'd13; start = 1'b1;
        step(); t = 1;
        start = 1'b0; dividend = 8'hAA; divisor = 8'h55;
        while (t < 4) begin step(); t++; end
        start = 1'b1; dividend = 8'd9; divisor = 8'd3;
        step(); t++;
        start = 1'b0; dividend = 8'd1; divisor = 8'd1;
        while (done !== 1'b1 && t < 20) begin step(); t++; end
        vectors += 3;
        if (t != int'(W) + 1) begin miscompares++; $display("FAIL ignore_latency got=%0d exp=%0d", t, W + 1); end
        if (quotient !== 8'd15) begin miscompares++; $display("FAIL ignore_quot got=%0d exp=15", quotient); end
        if (remainder !== 8'd5) begin miscompares++; $display("FAIL ignore_rem got=%0d exp=5", remainder); end
        step();
        // The ignored pulse must not have been queued.
        repeat (3) begin
            vectors++;
            if (busy !== 1'b0) begin miscompares++; $display("FAIL ignore_no_queue got busy=%b exp=0", busy); end
            step();
        end
    endtask

    task automatic test_held_start();
        int t = 0;
        int t2 = 0;
        dividend = 8'd200; divisor = 8'd13; start = 1'b1;
        step(); t = 1;
        dividend = 8'd10; divisor = 8'd3;
        while (done !== 1'b1 && t < 20) begin step(); t++; end
        vectors += 3;
        if (t != int'(W) + 1) begin miscompares++; $display("FAIL held_latency1 got=%0d exp=%0d", t, W + 1); end
        if (quotient !== 8'd15 || remainder !== 8'd5) begin
            miscompares++; $display("FAIL held_result1 got=%0d/%0d exp=15/5", quotient, remainder);
        end
        step(); t2 = 1;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL held_idle_gap got busy=%b exp=0", busy); end
        step(); t2++;
        start = 1'b0;
        while (done !== 1'b1 && t2 < 25) begin step(); t2++; end
        vectors += 2;
        if (t2 != int'(W) + 2) begin miscompares++; $display("FAIL held_period got=%0d exp=%0d", t2, W + 2); end
        if (quotient !== 8'd3 || remainder !== 8'd1) begin
            miscompares++; $display("FAIL held_result2 got=%0d/%0d exp=3/1", quotient, remainder);
        end
        step();
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] q, r;
        logic z;
        int lat;
        int pulses = 0;
        bit bok, pok;
        dividend = 8'd77; divisor = 8'd6; start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        vectors += 4;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_reset_busy got=%b exp=0", busy); end
        if (quotient !== 8'h00) begin miscompares++; $display("FAIL mid_reset_quot got=%h exp=00", quotient); end
        if (remainder !== 8'h00) begin miscompares++; $display("FAIL mid_reset_rem got=%h exp=00", remainder); end
        if (div_by_zero !== 1'b0) begin miscompares++; $display("FAIL mid_reset_dbz got=%b exp=0", div_by_zero); end
        repeat (12) begin
            if (done === 1'b1) pulses++;
            step();
        end
        vectors++;
        if (pulses != 0) begin miscompares++; $display("FAIL mid_reset_no_done got=%0d pulses exp=0", pulses); end
        do_op(8'd77, 8'd6, q, r, z, lat, bok, pok);
        vectors += 3;
        if (q !== 8'd12) begin miscompares++; $display("FAIL mid_reset_quot2 got=%0d exp=12", q); end
        if (r !== 8'd5) begin miscompares++; $display("FAIL mid_reset_rem2 got=%0d exp=5", r); end
        if (lat != int'(W) + 1) begin miscompares++; $display("FAIL mid_reset_latency got=%0d exp=%0d", lat, W + 1); end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, q, r, eq, er;
        logic z, ez;
        int lat, elat;
        bit bok, pok;
        for (int n = 0; n < 3000; n++) begin
            a = W'($urandom);
            case ($urandom_range(0, 15))
                0:       b = 8'h00;
                1:       b = 8'h01;
                2:       b = 8'hFF;
                3:       b = a;
                default: b = W'($urandom);
            endcase
            if (b == 8'h00) begin
                eq = 8'hFF; er = a; ez = 1'b1; elat = 1;
            end else begin
                eq = a / b; er = a % b; ez = 1'b0; elat = int'(W) + 1;
            end
            do_op(a, b, q, r, z, lat, bok, pok);
            vectors += 6;
            if (q !== eq) begin miscompares++; $display("FAIL rand_quot %0d/%0d got=%0d exp=%0d", a, b, q, eq); end
            if (r !== er) begin miscompares++; $display("FAIL rand_rem %0d/%0d got=%0d exp=%0d", a, b, r, er); end
            if (z !== ez) begin miscompares++; $display("FAIL rand_dbz %0d/%0d got=%b exp=%b", a, b, z, ez); end
            if (lat != elat) begin miscompares++; $display("FAIL rand_latency %0d/%0d got=%0d exp=%0d", a, b, lat, elat); end
            if (!bok) begin miscompares++; $display("FAIL rand_busy %0d/%0d got=low exp=high", a, b); end
            if (!pok) begin miscompares++; $display("FAIL rand_done_width %0d/%0d got=wide exp=1 cycle", a, b); end
            if (b != 8'h00) begin
                vectors++;
                if (!(r < b)) begin miscompares++; $display("FAIL rand_rem_bound got=%0d exp<%0d", r, b); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_ignore_start();
        test_held_start();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
